// File: rtl/flt2int_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flt2int_seq
// Purpose  : Batch sequencer for the float-to-integer converter core. On a
//            start falling edge it walks a table of 16-bit half-precision
//            operands held in the byte-wide data_mem. For each operand it
//            reads two bytes, hands the value to the converter over a req/ack
//            handshake (with a timeout), writes the 16-bit result back as two
//            bytes, and finally pulses done.
// Ports    : clk      - rising-edge clock
//            reset    - asynchronous active-low reset
//            start    - batch request, a batch begins on its falling edge
//            done     - one-cycle pulse at batch end
//            busy     - high from launch until the done cycle inclusive
//            dm_addr  - data_mem byte address
//            dm_rd    - data_mem read strobe (dm_out valid same cycle)
//            dm_wr    - data_mem write strobe
//            dm_in    - data_mem write data
//            dm_out   - data_mem read data
//            cvt_req  - operand valid to converter
//            cvt_flt  - half-precision operand
//            cvt_ack  - converter result valid
//            cvt_int  - converter result (two's complement)
//            sat_cnt  - saturated results in the last batch
//            tmo_cnt  - timed-out operands in the last batch
// Revision : 1.0 - initial release
// ============================================================================
module flt2int_seq #(
  parameter logic [7:0]  SRC_BASE = 8'd4,
  parameter logic [7:0]  DST_BASE = 8'd64,
  parameter logic [7:0]  COUNT    = 8'd1,
  parameter logic [15:0] TIMEOUT  = 16'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic        busy,
  output logic [7:0]  dm_addr,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic [7:0]  dm_in,
  input  logic [7:0]  dm_out,
  output logic        cvt_req,
  output logic [15:0] cvt_flt,
  input  logic        cvt_ack,
  input  logic [15:0] cvt_int,
  output logic [7:0]  sat_cnt,
  output logic [7:0]  tmo_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_LO = 3'd1;
  localparam logic [2:0] S_RD_HI = 3'd2;
  localparam logic [2:0] S_CVT   = 3'd3;
  localparam logic [2:0] S_WR_LO = 3'd4;
  localparam logic [2:0] S_WR_HI = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [15:0] c_sat_pos = 16'h7fff;
  localparam logic [15:0] c_sat_neg = 16'h8000;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [7:0]  r_idx;
  logic [7:0]  w_idx_nxt;
  logic        r_start_q;
  logic        w_launch;
  logic [15:0] r_flt;
  logic [15:0] r_res;
  logic [15:0] w_res;
  logic [15:0] r_tmr;
  logic        w_tmo_hit;
  logic        w_is_sat;
  logic [7:0]  w_src_addr;
  logic [7:0]  w_dst_addr;

  logic        r_done;
  logic        r_busy;
  logic [7:0]  r_dm_addr;
  logic        r_dm_rd;
  logic        r_dm_wr;
  logic [7:0]  r_dm_in;
  logic        r_cvt_req;
  logic [7:0]  r_sat_cnt;
  logic [7:0]  r_tmo_cnt;

  // --------------------------------------------------------------------------
  // Next-state logic. All strobes and addresses are registered from the
  // next state so they are glitch-free and line up with the state itself.
  // --------------------------------------------------------------------------
  always_comb begin
    w_launch    = r_start_q & ~start;
    w_tmo_hit   = (r_tmr == (TIMEOUT - 16'd1));
    w_is_sat    = (cvt_int == c_sat_pos) || (cvt_int == c_sat_neg);
    // A timed-out operand is reported as the negative saturation value.
    w_res       = cvt_ack ? cvt_int : c_sat_neg;
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;

    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_idx_nxt   = 8'd0;
          w_state_nxt = (COUNT == 8'd0) ? S_DONE : S_RD_LO;
        end
      end
      S_RD_LO: w_state_nxt = S_RD_HI;
      S_RD_HI: w_state_nxt = S_CVT;
      S_CVT: begin
        if (cvt_ack || w_tmo_hit) begin
          w_state_nxt = S_WR_LO;
        end
      end
      S_WR_LO: w_state_nxt = S_WR_HI;
      S_WR_HI: begin
        w_idx_nxt   = r_idx + 8'd1;
        w_state_nxt = ((r_idx + 8'd1) == COUNT) ? S_DONE : S_RD_LO;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Byte addresses wrap modulo 256 by construction of the 8-bit adders.
    w_src_addr = SRC_BASE + (w_idx_nxt << 1);
    w_dst_addr = DST_BASE + (w_idx_nxt << 1);
  end

  // --------------------------------------------------------------------------
  // State, datapath and output registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_idx     <= 8'd0;
      r_start_q <= 1'b0;
      r_flt     <= 16'd0;
      r_res     <= 16'd0;
      r_tmr     <= 16'd0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_dm_addr <= 8'd0;
      r_dm_rd   <= 1'b0;
      r_dm_wr   <= 1'b0;
      r_dm_in   <= 8'd0;
      r_cvt_req <= 1'b0;
      r_sat_cnt <= 8'd0;
      r_tmo_cnt <= 8'd0;
    end else begin
      r_start_q <= start;
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;

      r_dm_rd   <= (w_state_nxt == S_RD_LO) || (w_state_nxt == S_RD_HI);
      r_dm_wr   <= (w_state_nxt == S_WR_LO) || (w_state_nxt == S_WR_HI);
      r_cvt_req <= (w_state_nxt == S_CVT);
      r_done    <= (w_state_nxt == S_DONE);
      r_busy    <= (w_state_nxt != S_IDLE);

      // Address/data registers hold their last value outside RD/WR states.
      case (w_state_nxt)
        S_RD_LO: r_dm_addr <= w_src_addr;
        S_RD_HI: r_dm_addr <= w_src_addr + 8'd1;
        S_WR_LO: begin
          r_dm_addr <= w_dst_addr;
          r_dm_in   <= w_res[7:0];
        end
        S_WR_HI: begin
          r_dm_addr <= w_dst_addr + 8'd1;
          r_dm_in   <= r_res[15:8];
        end
        default: ;
      endcase

      if (r_state == S_RD_LO) r_flt[7:0]  <= dm_out;
      if (r_state == S_RD_HI) r_flt[15:8] <= dm_out;

      // Timer counts cycles spent in CVT; zero on every other state so it
      // starts from zero for each operand.
      r_tmr <= (r_state == S_CVT) ? (r_tmr + 16'd1) : 16'd0;

      if ((r_state == S_CVT) && (cvt_ack || w_tmo_hit)) begin
        r_res <= w_res;
      end

      if ((r_state == S_IDLE) && w_launch) begin
        r_sat_cnt <= 8'd0;
        r_tmo_cnt <= 8'd0;
      end else if (r_state == S_CVT) begin
        if (cvt_ack) begin
          if (w_is_sat && (r_sat_cnt != 8'hff)) r_sat_cnt <= r_sat_cnt + 8'd1;
        end else if (w_tmo_hit) begin
          if (r_tmo_cnt != 8'hff) r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
      end
    end
  end

  assign done    = r_done;
  assign busy    = r_busy;
  assign dm_addr = r_dm_addr;
  assign dm_rd   = r_dm_rd;
  assign dm_wr   = r_dm_wr;
  assign dm_in   = r_dm_in;
  assign cvt_req = r_cvt_req;
  assign cvt_flt = r_flt;
  assign sat_cnt = r_sat_cnt;
  assign tmo_cnt = r_tmo_cnt;

endmodule
`default_nettype wire

// File: tb/tb_flt2int_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_flt2int_seq
// Purpose  : Self-checking bench for flt2int_seq. Five instances with
//            different parameter sets share clock and reset; a byte memory
//            and a converter responder are modelled per instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flt2int_seq;

  localparam int N = 5;
  localparam logic [7:0]  P_SRC [N] = '{8'd4,  8'd4,  8'd4, 8'd4,  8'hFF};
  localparam logic [7:0]  P_CNT [N] = '{8'd1,  8'd3,  8'd2, 8'd0,  8'd1};
  localparam logic [15:0] P_TMO [N] = '{16'd64, 16'd64, 16'd4, 16'd64, 16'd64};
  localparam int DST = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] start, done, busy, dm_rd, dm_wr, cvt_req, cvt_ack;
  logic [7:0]   dm_addr [N];
  logic [7:0]   dm_in   [N];
  logic [7:0]   dm_out  [N];
  logic [7:0]   sat_cnt [N];
  logic [7:0]   tmo_cnt [N];
  logic [15:0]  cvt_flt [N];
  logic [15:0]  cvt_int [N];
  logic [7:0]   mem [N][256];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      flt2int_seq #(
        .SRC_BASE(P_SRC[gi]), .DST_BASE(8'(DST)), .COUNT(P_CNT[gi]), .TIMEOUT(P_TMO[gi])
      ) u_dut (
        .clk(clk), .reset(reset), .start(start[gi]), .done(done[gi]), .busy(busy[gi]),
        .dm_addr(dm_addr[gi]), .dm_rd(dm_rd[gi]), .dm_wr(dm_wr[gi]), .dm_in(dm_in[gi]),
        .dm_out(dm_out[gi]), .cvt_req(cvt_req[gi]), .cvt_flt(cvt_flt[gi]),
        .cvt_ack(cvt_ack[gi]), .cvt_int(cvt_int[gi]), .sat_cnt(sat_cnt[gi]),
        .tmo_cnt(tmo_cnt[gi])
      );
    end
  endgenerate

  int n_vec = 0;
  int n_err = 0;

  // run options
  int opt_dly [8];
  bit opt_never;
  int opt_restart;
  bit opt_rst_cvt;
  // run observations
  int res_lat, res_ndone, res_nrd, res_nwr, res_nbusy, res_maxreq;
  int cv_op, cv_run;
  bit rst_seen;
  logic [52:0] rst_outs;
  // model expectations
  logic [15:0] exp_res [8];
  int exp_lat, exp_sat, exp_tmo;

  // Half-precision to int16: truncate toward zero, saturate, inf/NaN by sign.
  function automatic logic [15:0] h2i(input logic [15:0] h);
    int e;
    longint mag;
    e = int'(h[14:10]);
    if (e == 31) return h[15] ? 16'h8000 : 16'h7fff;
    if (e == 0) return 16'h0000;
    mag = longint'(h[9:0]) + 64'sd1024;
    if (e >= 25) mag = mag << (e - 25);
    else mag = mag >> (25 - e);
    if (h[15]) begin
      if (mag >= 32768) return 16'h8000;
      return 16'(-mag);
    end
    if (mag >= 32767) return 16'h7fff;
    return 16'(mag);
  endfunction

  // Expected results from the operand table as it sits in memory now.
  task automatic model(input int d);
    int src, k;
    logic [15:0] op, res;
    exp_lat = 1; exp_sat = 0; exp_tmo = 0;
    for (int i = 0; i < int'(P_CNT[d]); i++) begin
      src = (int'(P_SRC[d]) + 2 * i) % 256;
      op  = {mem[d][(src + 1) % 256], mem[d][src]};
      if (!opt_never && opt_dly[i] < int'(P_TMO[d])) begin
        res = h2i(op);
        k   = opt_dly[i];
        if (res == 16'h7fff || res == 16'h8000) exp_sat++;
      end else begin
        res = 16'h8000;
        k   = int'(P_TMO[d]) - 1;
        exp_tmo++;
      end
      exp_res[i] = res;
      exp_lat += 5 + k;
    end
  endtask

  task automatic clear_mem(input int d);
    for (int a = 0; a < 256; a++) mem[d][a] = 8'($urandom);
  endtask

  task automatic defaults();
    opt_never = 1'b0; opt_restart = -100; opt_rst_cvt = 1'b0;
    for (int i = 0; i < 8; i++) opt_dly[i] = 0;
  endtask

  // Memory and converter service, called once per negedge.
  task automatic svc(input int d, input int cyc);
    if (dm_wr[d]) begin mem[d][dm_addr[d]] = dm_in[d]; res_nwr++; end
    if (dm_rd[d]) res_nrd++;
    dm_out[d] = mem[d][dm_addr[d]];
    if (cvt_req[d]) begin
      cvt_ack[d] = !opt_never && (cv_run == opt_dly[cv_op % 8]);
      cvt_int[d] = h2i(cvt_flt[d]);
      cv_run++;
      if (cv_run > res_maxreq) res_maxreq = cv_run;
    end else begin
      cvt_ack[d] = 1'b0;
      if (cv_run > 0) begin cv_op++; cv_run = 0; end
    end
    if (busy[d]) res_nbusy++;
    if (done[d]) begin
      res_ndone++;
      if (res_lat < 0) res_lat = cyc;
    end
  endtask

  // Pulse start, then observe ncyc cycles; res_lat counts from launch cycle.
  task automatic run(input int d, input int ncyc);
    res_lat = -1; res_ndone = 0; res_nrd = 0; res_nwr = 0; res_nbusy = 0; res_maxreq = 0;
    cv_op = 0; cv_run = 0; rst_seen = 1'b0; rst_outs = '1;
    @(negedge clk); start[d] = 1'b1; svc(d, 0);
    @(negedge clk); start[d] = 1'b0; svc(d, 0);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (rst_seen && reset == 1'b0) reset = 1'b1;
      if (c == opt_restart) start[d] = 1'b1;
      else if (c == opt_restart + 1) start[d] = 1'b0;
      if (opt_rst_cvt && !rst_seen && cvt_req[d]) begin
        reset = 1'b0;
        #1;
        rst_outs = {done[d], busy[d], dm_rd[d], dm_wr[d], cvt_req[d], dm_addr[d], dm_in[d],
                    cvt_flt[d], sat_cnt[d], tmo_cnt[d]};
        rst_seen = 1'b1;
        cvt_ack[d] = 1'b0;
      end else begin
        svc(d, c);
      end
    end
    defaults();
  endtask

  task automatic test_reset();
    logic [52:0] v;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      v = {done[d], busy[d], dm_rd[d], dm_wr[d], cvt_req[d], dm_addr[d], dm_in[d],
           cvt_flt[d], sat_cnt[d], tmo_cnt[d]};
      n_vec++;
      if (v !== '0) begin n_err++; $display("FAIL reset_outs[%0d]: got %h want 0", d, v); end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    clear_mem(0);
    mem[0][4] = 8'h00; mem[0][5] = 8'h3C;
    opt_dly[0] = 0;
    run(0, 15);
    n_vec++; if ({mem[0][DST+1], mem[0][DST]} !== 16'h0001) begin n_err++;
      $display("FAIL single_res: got %h want 0001", {mem[0][DST+1], mem[0][DST]}); end
    n_vec++; if (res_lat !== 6) begin n_err++; $display("FAIL single_lat: got %0d want 6", res_lat); end
    n_vec++; if (res_ndone !== 1) begin n_err++; $display("FAIL single_ndone: got %0d want 1", res_ndone); end
    n_vec++; if (res_nrd !== 2) begin n_err++; $display("FAIL single_nrd: got %0d want 2", res_nrd); end
    n_vec++; if (res_nbusy !== 6) begin n_err++; $display("FAIL single_busy: got %0d want 6", res_nbusy); end
  endtask

  task automatic test_batch();
    logic [15:0] want [3];
    want = '{16'hFFFD, 16'h7FFF, 16'h0000};
    clear_mem(1);
    {mem[1][5], mem[1][4]} = 16'hC200;
    {mem[1][7], mem[1][6]} = 16'h7BFF;
    {mem[1][9], mem[1][8]} = 16'h0000;
    for (int i = 0; i < 3; i++) opt_dly[i] = 2;
    run(1, 35);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({mem[1][DST+2*i+1], mem[1][DST+2*i]} !== want[i]) begin n_err++;
        $display("FAIL batch_res[%0d]: got %h want %h", i, {mem[1][DST+2*i+1], mem[1][DST+2*i]}, want[i]); end
    end
    n_vec++; if (sat_cnt[1] !== 8'd1) begin n_err++; $display("FAIL batch_sat: got %0d want 1", sat_cnt[1]); end
    n_vec++; if (tmo_cnt[1] !== 8'd0) begin n_err++; $display("FAIL batch_tmo: got %0d want 0", tmo_cnt[1]); end
    n_vec++; if (res_lat !== 22) begin n_err++; $display("FAIL batch_lat: got %0d want 22", res_lat); end
  endtask

  task automatic test_timeout();
    clear_mem(2);
    opt_never = 1'b1;
    run(2, 30);
    for (int i = 0; i < 2; i++) begin
      n_vec++; if ({mem[2][DST+2*i+1], mem[2][DST+2*i]} !== 16'h8000) begin n_err++;
        $display("FAIL tmo_res[%0d]: got %h want 8000", i, {mem[2][DST+2*i+1], mem[2][DST+2*i]}); end
    end
    n_vec++; if (tmo_cnt[2] !== 8'd2) begin n_err++; $display("FAIL tmo_cnt: got %0d want 2", tmo_cnt[2]); end
    n_vec++; if (sat_cnt[2] !== 8'd0) begin n_err++; $display("FAIL tmo_sat: got %0d want 0", sat_cnt[2]); end
    n_vec++; if (res_maxreq !== 4) begin n_err++; $display("FAIL tmo_req_len: got %0d want 4", res_maxreq); end
    n_vec++; if (res_lat !== 17) begin n_err++; $display("FAIL tmo_lat: got %0d want 17", res_lat); end
  endtask

  task automatic test_zero_count();
    clear_mem(3);
    run(3, 10);
    n_vec++; if (res_nrd + res_nwr !== 0) begin n_err++; $display("FAIL zero_mem_access: got %0d want 0", res_nrd + res_nwr); end
    n_vec++; if (res_lat !== 1) begin n_err++; $display("FAIL zero_lat: got %0d want 1", res_lat); end
    n_vec++; if (res_nbusy !== 1) begin n_err++; $display("FAIL zero_busy: got %0d want 1", res_nbusy); end
    n_vec++; if (res_ndone !== 1) begin n_err++; $display("FAIL zero_ndone: got %0d want 1", res_ndone); end
  endtask

  task automatic test_back_to_back();
    clear_mem(1);
    for (int i = 0; i < 3; i++) opt_dly[i] = int'($urandom_range(0, 3));
    model(1);
    opt_restart = 4;
    run(1, exp_lat + 40);
    n_vec++; if (res_ndone !== 1) begin n_err++; $display("FAIL b2b_ndone: got %0d want 1", res_ndone); end
    n_vec++; if (res_lat !== exp_lat) begin n_err++; $display("FAIL b2b_lat: got %0d want %0d", res_lat, exp_lat); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({mem[1][DST+2*i+1], mem[1][DST+2*i]} !== exp_res[i]) begin n_err++;
        $display("FAIL b2b_res[%0d]: got %h want %h", i, {mem[1][DST+2*i+1], mem[1][DST+2*i]}, exp_res[i]); end
    end
  endtask

  task automatic test_reset_abort();
    clear_mem(1);
    for (int i = 0; i < 3; i++) opt_dly[i] = 5;
    opt_rst_cvt = 1'b1;
    run(1, 60);
    n_vec++; if (rst_outs !== '0) begin n_err++; $display("FAIL abort_outs: got %h want 0", rst_outs); end
    n_vec++; if (res_ndone !== 0) begin n_err++; $display("FAIL abort_ndone: got %0d want 0", res_ndone); end
    n_vec++; if (res_nwr !== 0) begin n_err++; $display("FAIL abort_writes: got %0d want 0", res_nwr); end
    clear_mem(1);
    for (int i = 0; i < 3; i++) opt_dly[i] = int'($urandom_range(0, 4));
    model(1);
    run(1, exp_lat + 10);
    n_vec++; if (res_lat !== exp_lat) begin n_err++; $display("FAIL abort_rerun_lat: got %0d want %0d", res_lat, exp_lat); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({mem[1][DST+2*i+1], mem[1][DST+2*i]} !== exp_res[i]) begin n_err++;
        $display("FAIL abort_rerun_res[%0d]: got %h want %h", i, {mem[1][DST+2*i+1], mem[1][DST+2*i]}, exp_res[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] op;
    clear_mem(4);
    op = 16'(32'h3C00 + $urandom_range(0, 16'h1FFF));
    mem[4][255] = op[7:0];
    mem[4][0]   = op[15:8];
    opt_dly[0] = 1;
    run(4, 15);
    n_vec++; if ({mem[4][DST+1], mem[4][DST]} !== h2i(op)) begin n_err++;
      $display("FAIL wrap_res: got %h want %h (op %h)", {mem[4][DST+1], mem[4][DST]}, h2i(op), op); end
    n_vec++; if (res_lat !== 7) begin n_err++; $display("FAIL wrap_lat: got %0d want 7", res_lat); end
  endtask

  task automatic test_random();
    int d;
    int pick [8];
    pick = '{0, 1, 2, 3, 5, 62, 63, 64};
    for (int it = 0; it < 12; it++) begin
      d = it % 2;
      clear_mem(d);
      for (int i = 0; i < 3; i++) opt_dly[i] = pick[$urandom_range(0, 7)];
      model(d);
      run(d, exp_lat + 5);
      n_vec++; if (res_lat !== exp_lat) begin n_err++; $display("FAIL rand_lat[%0d]: got %0d want %0d", it, res_lat, exp_lat); end
      n_vec++; if (sat_cnt[d] !== 8'(exp_sat) || tmo_cnt[d] !== 8'(exp_tmo)) begin n_err++;
        $display("FAIL rand_cnts[%0d]: got sat %0d tmo %0d want sat %0d tmo %0d", it, sat_cnt[d], tmo_cnt[d], exp_sat, exp_tmo); end
      for (int i = 0; i < int'(P_CNT[d]); i++) begin
        n_vec++; if ({mem[d][DST+2*i+1], mem[d][DST+2*i]} !== exp_res[i]) begin n_err++;
          $display("FAIL rand_res[%0d.%0d]: got %h want %h", it, i, {mem[d][DST+2*i+1], mem[d][DST+2*i]}, exp_res[i]); end
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    start   = '0;
    cvt_ack = '0;
    for (int d = 0; d < N; d++) begin
      dm_out[d]  = 8'd0;
      cvt_int[d] = 16'd0;
    end
    defaults();
    test_reset();
    test_single();
    test_batch();
    test_timeout();
    test_zero_count();
    test_back_to_back();
    test_reset_abort();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
